rom_arbiter: RTL and testbench

Round-robin burst arbiter that shares the team's single-port 512x8 synchronous ROM (1-cycle registered read) between two requesters. Each requester asks for a burst of 1–16 consecutive words; the arbiter grants one burst at a time, drives the ROM address one word per cycle, and returns each word with a valid strobe routed to the burst owner. It sits between the ROM and the two consumer blocks; the ROM instance is unchanged.

---
 rtl/rom_arbiter.sv | 154 +++++++++++++++
 tb/tb_rom_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Round-robin burst arbiter in front of a single-port 512x8 synchronous ROM.
// Two requesters share the ROM: one burst of 1..16 words at a time, one word per cycle.
module rom_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [LEN_W-1:0]  Len0,
    input  logic [LEN_W-1:0]  Len1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              Valid0,
    output logic              Valid1,
    output logic [DATA_W-1:0] Data0,
    output logic [DATA_W-1:0] Data1,
    output logic              Done0,
    output logic              Done1,
    output logic              Busy,
    output logic [ADDR_W-1:0] Endereco,
    input  logic [DATA_W-1:0] Dados
);

    typedef enum logic {IDLE, BURST} state_t;

    // One return-path tag per issued ROM address.
    typedef struct packed {
        logic valid;
        logic owner;
        logic last;
    } tag_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(16);

    state_t            state, state_nx;
    logic              prio, prio_nx;
    logic              owner, owner_nx;
    logic              win;
    logic              gnt0_nx, gnt1_nx;
    logic [LEN_W-1:0]  cnt, cnt_nx, sel_len;
    logic [ADDR_W-1:0] addr_nx;
    tag_t              issue, s1, s2;

    // A zero length still fetches one word; anything above 16 is clipped.
    function automatic logic [LEN_W-1:0] len_eff(input logic [LEN_W-1:0] len);
        if (len == '0)
            return LEN_ONE;
        else if (len > LEN_MAX)
            return LEN_MAX;
        else
            return len;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        prio_nx  = prio;
        owner_nx = owner;
        cnt_nx   = cnt;
        addr_nx  = Endereco;
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        issue    = '0;
        win      = (Req0 && Req1) ? prio : Req1;
        sel_len  = len_eff(win ? Len1 : Len0);

        case (state)
            IDLE: begin
                if (Req0 || Req1) begin
                    addr_nx     = win ? Addr1 : Addr0;
                    cnt_nx      = sel_len - LEN_ONE;
                    owner_nx    = win;
                    prio_nx     = ~win;
                    gnt0_nx     = ~win;
                    gnt1_nx     = win;
                    issue.valid = 1'b1;
                    issue.owner = win;
                    issue.last  = (sel_len == LEN_ONE);
                    state_nx    = (sel_len == LEN_ONE) ? IDLE : BURST;
                end
            end
            BURST: begin
                // Requests are not looked at here; a held request waits for IDLE.
                addr_nx     = Endereco + 1'b1;
                cnt_nx      = cnt - LEN_ONE;
                issue.valid = 1'b1;
                issue.owner = owner;
                issue.last  = (cnt == LEN_ONE);
                if (cnt == LEN_ONE)
                    state_nx = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and simulation matches the synthesized hardware.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            cnt      <= '0;
            Endereco <= '0;
            Gnt0     <= 1'b0;
            Gnt1     <= 1'b0;
        end else begin
            state    <= state_nx;
            prio     <= prio_nx;
            owner    <= owner_nx;
            cnt      <= cnt_nx;
            Endereco <= addr_nx;
            Gnt0     <= gnt0_nx;
            Gnt1     <= gnt1_nx;
        end
    end

    // Stage 1 tracks the address being presented, stage 2 the cycle the ROM
    // drives its data, after which the word is latched for its owner.
    // NOTE: the tags and output data are reset too, so a reset mid-burst drops
    // every in-flight word instead of letting it surface after release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1     <= '0;
            s2     <= '0;
            Valid0 <= 1'b0;
            Valid1 <= 1'b0;
            Done0  <= 1'b0;
            Done1  <= 1'b0;
            Data0  <= '0;
            Data1  <= '0;
        end else begin
            s1     <= issue;
            s2     <= s1;
            Valid0 <= s2.valid && !s2.owner;
            Valid1 <= s2.valid &&  s2.owner;
            Done0  <= s2.valid && !s2.owner && s2.last;
            Done1  <= s2.valid &&  s2.owner && s2.last;
            if (s2.valid && !s2.owner)
                Data0 <= Dados;
            if (s2.valid && s2.owner)
                Data1 <= Dados;
        end
    end

    assign Busy = (state == BURST) || s1.valid || s2.valid || Valid0 || Valid1;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a behavioural ROM, per-requester scoreboards
// filled when a request is driven and drained by a negedge monitor.
module tb_rom_arbiter;

    logic       CLK, RST_N;
    logic       Req0, Req1;
    logic [8:0] Addr0, Addr1, Endereco;
    logic [4:0] Len0, Len1;
    logic       Gnt0, Gnt1, Valid0, Valid1, Done0, Done1, Busy;
    logic [7:0] Data0, Data1, Dados;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [4:0] k;
    } exp_t;

    exp_t       exp_q0[$], exp_q1[$];
    int         gnt_q0[$], gnt_q1[$];
    logic [7:0] rom [512];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         base0 = 0, base1 = 0;
    logic       gnt0_prev = 1'b0, gnt1_prev = 1'b0;

    rom_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .Req0(Req0), .Req1(Req1),
        .Addr0(Addr0), .Addr1(Addr1),
        .Len0(Len0), .Len1(Len1),
        .Gnt0(Gnt0), .Gnt1(Gnt1),
        .Valid0(Valid0), .Valid1(Valid1),
        .Data0(Data0), .Data1(Data1),
        .Done0(Done0), .Done1(Done1),
        .Busy(Busy), .Endereco(Endereco), .Dados(Dados)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        Dados <= rom[Endereco];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every returned word is checked for data, Done and its cycle relative to Gnt.
    always @(negedge CLK) begin
        exp_t e;
        if (gnt0_prev) check("gnt0_one_cycle", Gnt0, 0);
        if (gnt1_prev) check("gnt1_one_cycle", Gnt1, 0);
        if (Gnt0 && Gnt1) check("gnt_both", {Gnt0, Gnt1}, 2'b01);
        if (Gnt0) gnt_q0.push_back(cyc);
        if (Gnt1) gnt_q1.push_back(cyc);
        if (Done0 && !Valid0) check("done0_alone", Done0, 0);
        if (Done1 && !Valid1) check("done1_alone", Done1, 0);
        if (Valid0) begin
            if (exp_q0.size() == 0) check("valid0_unexpected", Valid0, 0);
            else begin
                e = exp_q0.pop_front();
                if (e.k == 0 && gnt_q0.size() != 0) base0 = gnt_q0.pop_front();
                check("data0", Data0, e.data);
                check("done0", Done0, e.last);
                check("latency0", cyc, base0 + 2 + int'(e.k));
            end
        end
        if (Valid1) begin
            if (exp_q1.size() == 0) check("valid1_unexpected", Valid1, 0);
            else begin
                e = exp_q1.pop_front();
                if (e.k == 0 && gnt_q1.size() != 0) base1 = gnt_q1.pop_front();
                check("data1", Data1, e.data);
                check("done1", Done1, e.last);
                check("latency1", cyc, base1 + 2 + int'(e.k));
            end
        end
        gnt0_prev = Gnt0;
        gnt1_prev = Gnt1;
    end

    task automatic start_req(input int r, input logic [8:0] addr, input logic [4:0] len);
        int         n;
        logic [8:0] a;
        exp_t       e;
        n = (len == 0) ? 1 : (len > 16) ? 16 : int'(len);
        for (int k = 0; k < n; k++) begin
            a      = addr + 9'(k);
            e.data = rom[a];
            e.last = (k == n - 1);
            e.k    = 5'(k);
            if (r == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
        if (r == 0) begin Req0 = 1'b1; Addr0 = addr; Len0 = len; end
        else        begin Req1 = 1'b1; Addr1 = addr; Len1 = len; end
    endtask

    // Returns at the negedge where Gnt is high; the request is dropped and its
    // fields scrambled, which the arbiter must ignore.
    task automatic wait_gnt(input int r, input logic [8:0] addr, output int gc);
        logic seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge CLK);
            if ((r == 0) ? Gnt0 : Gnt1) begin seen = 1'b1; break; end
        end
        check($sformatf("gnt%0d_seen", r), seen, 1);
        check($sformatf("gnt%0d_addr", r), Endereco, addr);
        gc = cyc;
        if (r == 0) begin Req0 = 1'b0; Addr0 = 9'($urandom); Len0 = 5'($urandom); end
        else        begin Req1 = 1'b0; Addr1 = 9'($urandom); Len1 = 5'($urandom); end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (exp_q0.size() == 0 && exp_q1.size() == 0 && !Busy) break;
        end
        check({tag, "_left0"}, exp_q0.size(), 0);
        check({tag, "_left1"}, exp_q1.size(), 0);
        check({tag, "_busy"}, Busy, 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        logic [7:0] init_vals [10] = '{8'd2, 8'd6, 8'd7, 8'd2, 8'd2, 8'd0, 8'd255, 8'd3, 8'd255, 8'd1};
        int g0, g1, g0b, nv, stray;

        for (int i = 0; i < 512; i++) rom[i] = 8'hFF;
        for (int i = 0; i < 10; i++) rom[i] = init_vals[i];
        RST_N = 1'b0;
        Req0 = 1'b0; Req1 = 1'b0;
        Addr0 = '0; Addr1 = '0; Len0 = '0; Len1 = '0;
        repeat (3) @(negedge CLK);
        check("rst_gnt", {Gnt0, Gnt1}, 0);
        check("rst_valid_done", {Valid0, Valid1, Done0, Done1}, 0);
        check("rst_busy", Busy, 0);
        check("rst_addr", Endereco, 0);
        check("rst_data", {Data0, Data1}, 0);
        RST_N = 1'b1;

        // Single burst from requester 0.
        @(negedge CLK);
        start_req(0, 9'd0, 5'd4);
        wait_gnt(0, 9'd0, g0);
        for (int i = 0; i < 20 && !Done0; i++) @(negedge CLK);
        check("single_done_cycle", cyc, g0 + 5);
        check("single_busy_last", Busy, 1);
        @(negedge CLK);
        check("single_busy_fall", Busy, 0);
        wait_drain("single");

        // Contention from reset: 0 wins, then 1 back-to-back, then 1 beats a re-raised 0.
        do_reset();
        @(negedge CLK);
        start_req(0, 9'd5, 5'd2);
        start_req(1, 9'd7, 5'd3);
        wait_gnt(0, 9'd5, g0);
        start_req(0, 9'd5, 5'd2);
        wait_gnt(1, 9'd7, g1);
        wait_gnt(0, 9'd5, g0b);
        check("rr_gap_0_to_1", g1 - g0, 2);
        check("rr_gap_1_to_0", g0b - g1, 3);
        wait_drain("rr");

        // Address wrap 510 -> 1.
        @(negedge CLK);
        start_req(1, 9'd510, 5'd4);
        wait_gnt(1, 9'd510, g1);
        for (int k = 1; k < 4; k++) begin
            logic [8:0] a;
            a = 9'd510 + 9'(k);
            @(negedge CLK);
            check($sformatf("wrap_addr_%0d", k), Endereco, a);
        end
        wait_drain("wrap");

        // Length edges: 0 gives one word, 31 gives sixteen.
        @(negedge CLK);
        start_req(0, 9'd7, 5'd0);
        wait_gnt(0, 9'd7, g0);
        wait_drain("len0");
        @(negedge CLK);
        start_req(0, 9'd0, 5'd31);
        wait_gnt(0, 9'd0, g0);
        wait_drain("len31");

        // Reset on the third returned word of a 16-word burst.
        @(negedge CLK);
        start_req(0, 9'd0, 5'd16);
        wait_gnt(0, 9'd0, g0);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (Valid0) nv++;
            if (nv == 3) break;
        end
        check("midrst_third_valid", nv, 3);
        #1 RST_N = 1'b0;
        exp_q0.delete();
        gnt_q0.delete();
        #1;
        check("midrst_gnt", {Gnt0, Gnt1}, 0);
        check("midrst_valid_done", {Valid0, Valid1, Done0, Done1}, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_addr", Endereco, 0);
        check("midrst_data", {Data0, Data1}, 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge CLK);
            if (Valid0 || Valid1) stray++;
        end
        check("midrst_no_stray_valid", stray, 0);
        start_req(0, 9'd9, 5'd1);
        wait_gnt(0, 9'd9, g0);
        wait_drain("midrst_after");

        // Requester 0 held through a 16-word burst of requester 1.
        @(negedge CLK);
        start_req(1, 9'd0, 5'd16);
        start_req(0, 9'd2, 5'd3);
        wait_gnt(1, 9'd0, g1);
        wait_gnt(0, 9'd2, g0);
        check("held_gap", g0 - g1, 16);
        wait_drain("held");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
